// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates and formats loads/stores, runs a
// req/ack data-memory transaction with timeout, and stalls the pipeline meanwhile.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic        stall,
    output logic [31:0] data_result,
    output logic        result_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] data_result_q, data_result_d;
    logic        result_valid_q, result_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        op_ok, f3_legal, aligned, accept, reject_mis;
    logic [31:0] wdata_fmt;
    logic [3:0]  be_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    // Request decode and alignment
    always_comb begin
        op_ok = ex_valid && (ex_is_load ^ ex_is_store);
        if (ex_is_load)
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010)
                    || (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        else
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        case (ex_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !ex_addr[0];
            2'b10:   aligned = (ex_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        accept     = (state_q == IDLE) && op_ok && f3_legal && aligned;
        reject_mis = (state_q == IDLE) && op_ok && f3_legal && !aligned;
    end

    // Store lane replication and byte enables
    always_comb begin
        wdata_fmt = '0;
        be_fmt    = 4'b1111;
        if (ex_is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    wdata_fmt = {4{ex_store_data[7:0]}};
                    be_fmt    = 4'b0001 << ex_addr[1:0];
                end
                2'b01: begin
                    wdata_fmt = {2{ex_store_data[15:0]}};
                    be_fmt    = ex_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: wdata_fmt = ex_store_data;
            endcase
        end
    end

    // Load lane select and extension
    always_comb begin
        case (lo_q)
            2'b00:   rd_byte = mem_rdata[7:0];
            2'b01:   rd_byte = mem_rdata[15:8];
            2'b10:   rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_fmt = {24'h0, rd_byte};
            3'b101:  load_fmt = {16'h0, rd_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_load_d      = is_load_q;
        f3_d           = f3_q;
        lo_d           = lo_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        data_result_d  = data_result_q;
        result_valid_d = 1'b0;
        misaligned_d   = 1'b0;
        bus_error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_load_d   = ex_is_load;
                    f3_d        = ex_funct3;
                    lo_d        = ex_addr[1:0];
                    mem_req_d   = 1'b1;
                    mem_we_d    = ex_is_store;
                    mem_addr_d  = {ex_addr[31:2], 2'b00};
                    mem_wdata_d = wdata_fmt;
                    mem_be_d    = be_fmt;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end else if (reject_mis) begin
                    misaligned_d = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // Ack takes priority over a coincident timeout
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (is_load_q) begin
                        data_result_d  = load_fmt;
                        result_valid_d = 1'b1;
                    end
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    if (is_load_q)
                        data_result_d = '0;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            is_load_q      <= 1'b0;
            f3_q           <= '0;
            lo_q           <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= '0;
            data_result_q  <= '0;
            result_valid_q <= 1'b0;
            misaligned_q   <= 1'b0;
            bus_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            is_load_q      <= is_load_d;
            f3_q           <= f3_d;
            lo_q           <= lo_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            data_result_q  <= data_result_d;
            result_valid_q <= result_valid_d;
            misaligned_q   <= misaligned_d;
            bus_error_q    <= bus_error_d;
        end
    end

    // Stall is forced low during reset even if EX still presents a valid op
    assign stall        = !rst && (accept || (state_q == BUSY));
    assign data_result  = data_result_q;
    assign result_valid = result_valid_q;
    assign misaligned   = misaligned_q;
    assign bus_error    = bus_error_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory requests and response
// events are queued by the stimulus and checked by independent monitors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic        stall;
    logic [31:0] data_result;
    logic        result_valid, misaligned, bus_error;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          kind;   // 0 load result, 1 misaligned, 2 bus error
        logic [31:0] data;
    } evt_t;

    req_t req_q[$];
    evt_t evt_q[$];

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .stall(stall), .data_result(data_result), .result_valid(result_valid),
        .misaligned(misaligned), .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Request monitor: every cycle mem_req is high the fields must match the
    // queued expectation; the entry retires when mem_req drops.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_q.size() == 0) begin
                chk("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, req_q[0].we});
                chk("mem_addr", mem_addr, req_q[0].addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, req_q[0].be});
                if (req_q[0].we)
                    chk("mem_wdata", mem_wdata, req_q[0].wdata);
            end
        end else if (prev_req && req_q.size() != 0) begin
            void'(req_q.pop_front());
        end
        prev_req <= mem_req;
    end

    // Response monitor
    always @(negedge clk) begin
        if (result_valid || misaligned || bus_error) begin
            int   k;
            evt_t e;
            k = result_valid ? 0 : (misaligned ? 1 : 2);
            chk("single_flag", {29'd0, result_valid, misaligned, bus_error} & ({29'd0, result_valid, misaligned, bus_error} - 32'd1), 32'd0);
            if (evt_q.size() == 0) begin
                chk("unexpected_event", k, 32'hFFFF_FFFF);
            end else begin
                e = evt_q.pop_front();
                chk("event_kind", k, e.kind);
                chk("data_result", data_result, e.data);
            end
        end
    end

    task automatic exp_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wd; r.be = be;
        req_q.push_back(r);
    endtask

    task automatic exp_evt(input int kind, input logic [31:0] data);
        evt_t e;
        e.kind = kind; e.data = data;
        evt_q.push_back(e);
    endtask

    // Present one op, then act as memory: ack on BUSY cycle ack_at (0 = never).
    task automatic do_op(input string name, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_at, input int exp_stalls);
        int stalls = 0;
        int busy = 0;
        bit done = 0;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata;
        #1;
        if (stall) stalls++;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) begin
                done = 1;
                break;
            end
            if (stall) stalls++;
            busy++;
            if (busy == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_stalls"}, stalls, exp_stalls);
        chk({name, "_stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_data_result", data_result, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        rst = 1'b0;

        exp_req(1'b0, 32'h100, 32'h0, 4'b1111);
        exp_evt(0, 32'hDEADBEEF);
        do_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2);

        exp_req(1'b0, 32'h100, 32'h0, 4'b1111);
        exp_evt(0, 32'hFFFFFF80);
        do_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 2);

        exp_req(1'b0, 32'h100, 32'h0, 4'b1111);
        exp_evt(0, 32'h00000080);
        do_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2, 3);

        exp_req(1'b1, 32'h200, 32'hABCDABCD, 4'b1100);
        do_op("sh", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 4);

        exp_evt(1, 32'h00000080);
        do_op("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 0);

        exp_req(1'b0, 32'h10, 32'h0, 4'b1111);
        exp_evt(0, 32'hFFFF9ABC);
        do_op("lh_hi", 1, 0, 3'b001, 32'h12, 32'h0, 32'h9ABC1234, 1, 2);

        exp_req(1'b0, 32'h10, 32'h0, 4'b1111);
        exp_evt(0, 32'h00001234);
        do_op("lhu_lo", 1, 0, 3'b101, 32'h10, 32'h0, 32'h9ABC1234, 1, 2);

        exp_req(1'b1, 32'h40, 32'h12345678, 4'b1111);
        do_op("sw", 0, 1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1, 2);

        do_op("ill_f3", 1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 0);
        do_op("both", 1, 1, 3'b010, 32'h0, 32'h0, 32'h0, 1, 0);
        do_op("sb_f3_bad", 0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 0);

        exp_req(1'b0, 32'h10, 32'h0, 4'b1111);
        exp_evt(2, 32'h0);
        do_op("lh_timeout", 1, 0, 3'b001, 32'h10, 32'h0, 32'h0, 0, 5);

        // Reset while BUSY
        exp_req(1'b0, 32'h300, 32'h0, 4'b1111);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h300;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy_data", data_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
        chk("stray_ack_data", data_result, 32'd0);

        exp_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'b0010);
        do_op("sb", 0, 1, 3'b000, 32'h1, 32'h0000005A, 32'h0, 1, 2);

        repeat (3) @(negedge clk);
        chk("req_queue_empty", req_q.size(), 32'd0);
        chk("evt_queue_empty", evt_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
